// File: rtl/ccff_chain_loader.sv
// Bitstream-to-ccff chain loader: streams words LSB-first into a configuration chain.
// Optional recirculating parity readback of the chain when CCFF_READBACK_EN is defined.
module ccff_chain_loader #(
  parameter int unsigned CHAIN_LEN = 29,
  parameter int unsigned WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              start,
  input  logic [WORD_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int unsigned NUM_WORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int unsigned BIT_CW    = $clog2(CHAIN_LEN + 1);
  localparam int unsigned WRD_CW    = $clog2(NUM_WORDS + 1);
  localparam int unsigned SR_CW     = $clog2(WORD_W + 1);
  localparam logic [BIT_CW-1:0] LAST_BIT = BIT_CW'(CHAIN_LEN - 1);

`ifdef CCFF_READBACK_EN
  typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif

  state_t              state;
  logic [WORD_W-1:0]   hold_q;
  logic [WORD_W-1:0]   sr_q;
  logic                hold_valid;
  logic [SR_CW-1:0]    sr_cnt;
  logic [BIT_CW-1:0]   bit_cnt;
  logic [WRD_CW-1:0]   word_cnt;
  logic                load_par;
  logic                sr_live;
  logic                cur_bit;
  logic                load_shift;

`ifdef CCFF_READBACK_EN
  logic                tail_par;
  logic                error_q;
  assign error = error_q;
`else
  logic                unused_sink;
  assign error       = 1'b0;
  assign unused_sink = ccff_tail ^ load_par;
`endif

  // With the shift register empty, the head bit comes straight from the holding
  // register so the first shift lands the cycle after the first handshake.
  always_comb begin
    sr_live       = (sr_cnt != '0);
    cur_bit       = sr_live ? sr_q[0] : hold_q[0];
    load_shift    = (state == LOAD) && (sr_live || hold_valid);
    bs_ready      = (state == LOAD) && !hold_valid && (word_cnt != WRD_CW'(NUM_WORDS));
    ccff_shift_en = load_shift;
    ccff_head     = load_shift & cur_bit;
    busy          = (state == LOAD);
    done          = (state == DONE);
`ifdef CCFF_READBACK_EN
    if (state == VERIFY) begin
      ccff_shift_en = 1'b1;
      ccff_head     = ccff_tail;
      busy          = 1'b1;
    end
`endif
  end

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      state      <= IDLE;
      hold_q     <= '0;
      sr_q       <= '0;
      hold_valid <= 1'b0;
      sr_cnt     <= '0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      load_par   <= 1'b0;
`ifdef CCFF_READBACK_EN
      tail_par   <= 1'b0;
      error_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= LOAD;
            bit_cnt    <= '0;
            word_cnt   <= '0;
            sr_cnt     <= '0;
            hold_valid <= 1'b0;
            load_par   <= 1'b0;
`ifdef CCFF_READBACK_EN
            tail_par   <= 1'b0;
            error_q    <= 1'b0;
`endif
          end
        end
        LOAD: begin
          if (bs_valid && bs_ready) begin
            hold_q     <= bs_data;
            hold_valid <= 1'b1;
            word_cnt   <= word_cnt + 1'b1;
          end
          if (load_shift) begin
            load_par <= load_par ^ cur_bit;
            bit_cnt  <= bit_cnt + 1'b1;
            if (!sr_live) begin
              sr_q       <= hold_q >> 1;
              sr_cnt     <= SR_CW'(WORD_W - 1);
              hold_valid <= 1'b0;
            end else if (sr_cnt == SR_CW'(1) && hold_valid) begin
              sr_q       <= hold_q;
              sr_cnt     <= SR_CW'(WORD_W);
              hold_valid <= 1'b0;
            end else begin
              sr_q   <= sr_q >> 1;
              sr_cnt <= sr_cnt - 1'b1;
            end
            // Final shift: drop leftover bits of the last word and any held word.
            if (bit_cnt == LAST_BIT) begin
              sr_cnt     <= '0;
              hold_valid <= 1'b0;
              bit_cnt    <= '0;
`ifdef CCFF_READBACK_EN
              state      <= VERIFY;
`else
              state      <= DONE;
`endif
            end
          end
        end
`ifdef CCFF_READBACK_EN
        VERIFY: begin
          tail_par <= tail_par ^ ccff_tail;
          bit_cnt  <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
            error_q <= ((tail_par ^ ccff_tail) != load_par);
            bit_cnt <= '0;
            state   <= DONE;
          end
        end
`endif
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader with a behavioural shift-register chain model.
// Covers back-to-back and gapped loads, start during load, mid-load reset, readback.
module tb_ccff_chain_loader;

  localparam int CL = 29;
  localparam int WW = 8;
`ifdef CCFF_READBACK_EN
  localparam int TOT = 2 * CL;
`else
  localparam int TOT = CL;
`endif

  logic          prog_clk = 1'b0;
  logic          prog_rst_n;
  logic          start;
  logic [WW-1:0] bs_data;
  logic          bs_valid;
  logic          bs_ready;
  logic          ccff_head;
  logic          ccff_shift_en;
  logic          ccff_tail;
  logic          busy;
  logic          done;
  logic          error;

  ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
    .prog_clk(prog_clk), .prog_rst_n(prog_rst_n), .start(start),
    .bs_data(bs_data), .bs_valid(bs_valid), .bs_ready(bs_ready),
    .ccff_head(ccff_head), .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail),
    .busy(busy), .done(done), .error(error)
  );

  always #5 prog_clk = ~prog_clk;

  int vectors = 0;
  int miscompares = 0;

  // Chain model: head enters bit 0, tail is bit CL-1.
  logic [CL-1:0] chain = '0;
  logic          inv_tail = 1'b0;
  assign ccff_tail = chain[CL-1] ^ inv_tail;

  logic        clr = 1'b0;
  int          cyc = 0;
  int          run_shifts = 0;
  int          run_hs = 0;
  int          run_done = 0;
  int          first_sh = 0;
  int          last_sh = 0;
  logic [63:0] cap = '0;

  always @(posedge prog_clk) begin
    cyc = cyc + 1;
    if (clr) begin
      run_shifts = 0;
      run_hs     = 0;
      run_done   = 0;
      first_sh   = 0;
      last_sh    = 0;
      cap        = '0;
    end else begin
      if (ccff_shift_en) begin
        if (run_shifts < 64) cap[run_shifts] = ccff_head;
        if (run_shifts == 0) first_sh = cyc;
        last_sh    = cyc;
        run_shifts = run_shifts + 1;
        chain     <= {chain[CL-2:0], ccff_head};
      end
      if (bs_valid && bs_ready) run_hs = run_hs + 1;
      if (done) run_done = run_done + 1;
    end
  end

  logic [7:0]    words [4] = '{8'hA5, 8'h3C, 8'hFF, 8'h01};
  logic [31:0]   stream = 32'h01FF3CA5;
  logic [CL-1:0] exp_bits;
  logic [CL-1:0] exp_chain;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_load(input string tag, input int gap, input bit pulse_start,
                          input bit inject, input bit exp_err);
    int k;
    clr = 1'b1;
    @(negedge prog_clk);
    clr = 1'b0;
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    check({tag, "_busy_after_start"}, busy, 1);
    check({tag, "_ready_after_start"}, bs_ready, 1);
    check({tag, "_error_cleared"}, error, 0);
    for (int w = 0; w < 4; w++) begin
      bs_data  = words[w];
      bs_valid = 1'b1;
      k = 0;
      while (!bs_ready && k < 100) begin
        @(negedge prog_clk);
        k++;
      end
      if (k >= 100) check({tag, "_handshake_timeout"}, 0, 1);
      @(negedge prog_clk);
      if (gap > 0) begin
        bs_valid = 1'b0;
        repeat (gap) @(negedge prog_clk);
      end
      if (pulse_start && w == 1) begin
        start = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
      end
    end
    bs_data  = 8'hEE;
    bs_valid = 1'b1;
    @(negedge prog_clk);
    check({tag, "_ready_after_quota"}, bs_ready, 0);
    k = 0;
    while (!done && k < 300) begin
      inv_tail = inject && (run_shifts == 40);
      @(negedge prog_clk);
      k++;
    end
    inv_tail = 1'b0;
    check({tag, "_done_seen"}, (k < 300), 1);
    check({tag, "_busy_at_done"}, busy, 0);
    check({tag, "_error_at_done"}, error, exp_err);
    bs_valid = 1'b0;
    @(negedge prog_clk);
    check({tag, "_done_one_cycle"}, done, 0);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_done_count"}, run_done, 1);
    check({tag, "_word_count"}, run_hs, 4);
    check({tag, "_shift_count"}, run_shifts, TOT);
    check({tag, "_head_bits"}, cap[CL-1:0], exp_bits);
    if (!inject) check({tag, "_chain_contents"}, chain, exp_chain);
    if (gap == 0) check({tag, "_shift_run_len"}, last_sh - first_sh + 1, TOT);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < CL; i++) begin
      exp_bits[i]          = stream[i];
      exp_chain[CL - 1 - i] = stream[i];
    end
    prog_rst_n = 1'b0;
    start      = 1'b0;
    bs_data    = '0;
    bs_valid   = 1'b0;
    #1;
    check("reset_outputs", {bs_ready, ccff_head, ccff_shift_en, busy, done, error}, 6'b0);
    repeat (2) @(negedge prog_clk);
    prog_rst_n = 1'b1;
    @(negedge prog_clk);
    check("idle_busy", busy, 0);
    check("idle_ready", bs_ready, 0);
    check("idle_shift_en", ccff_shift_en, 0);

    run_load("b2b", 0, 1'b0, 1'b0, 1'b0);
    run_load("gap", 5, 1'b1, 1'b0, 1'b0);

    // Abandon a load partway through with an asynchronous reset.
    clr = 1'b1;
    @(negedge prog_clk);
    clr = 1'b0;
    start = 1'b1;
    @(negedge prog_clk);
    start    = 1'b0;
    bs_data  = 8'hA5;
    bs_valid = 1'b1;
    repeat (6) @(negedge prog_clk);
    check("midload_busy", busy, 1);
    #2 prog_rst_n = 1'b0;
    #1;
    check("midload_reset_outputs", {bs_ready, ccff_head, ccff_shift_en, busy, done, error}, 6'b0);
    @(negedge prog_clk);
    prog_rst_n = 1'b1;
    bs_valid   = 1'b0;
    repeat (3) @(negedge prog_clk);
    check("post_reset_idle", {bs_ready, ccff_shift_en, busy, done}, 4'b0);

    run_load("after_reset", 0, 1'b0, 1'b0, 1'b0);

`ifdef CCFF_READBACK_EN
    run_load("fault", 0, 1'b0, 1'b1, 1'b1);
    repeat (3) @(negedge prog_clk);
    check("error_sticky", error, 1);
    run_load("recover", 0, 1'b0, 1'b0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
